// File: rtl/wrf_channel_arbiter.sv
// wrf_channel_arbiter: round-robin arbiter sharing one in-order write-fence
// TX1 channel among NUM_REQ write requesters. Multi-beat bursts hold the
// channel until their last beat. The channel almost-full throttles every grant,
// and a drain request parks the arbiter at the next burst boundary.
//
// Optional feature macro: ASE_WRARB_WATCHDOG_EN
//   defined     -> per-requester wait counters drive a sticky starve_err_o
//                  (also reported on the console when ASE_DEBUG is defined)
//   not defined -> no counters, starve_err_o is tied low
module wrf_channel_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HDR_WIDTH    = 61,
    parameter int DATA_WIDTH   = 512,
    parameter int STARVE_LIMIT = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ-1:0]              req_last_i,
    input  logic [NUM_REQ*HDR_WIDTH-1:0]    req_meta_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic                            ch_full_i,
    output logic                            ch_write_en_o,
    output logic [HDR_WIDTH-1:0]            ch_meta_o,
    output logic [DATA_WIDTH-1:0]           ch_data_o,
    input  logic                            drain_req_i,
    output logic                            drained_o,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id_o,
    output logic [31:0]                     beat_count_o,
    output logic                            starve_err_o
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDW-1:0]     LAST_ID  = IDW'(NUM_REQ - 1);

    // Parameter sanity checks at elaboration time.
    if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
        $error("wrf_channel_arbiter: NUM_REQ must be within 2..8");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
        $error("wrf_channel_arbiter: STARVE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                 state_q;
    logic [IDW-1:0]         rr_ptr_q;
    logic [IDW-1:0]         grant_q;
    logic                   run_q;        // low while in reset and for the first edge after it
    logic                   ch_we_q;
    logic [HDR_WIDTH-1:0]   ch_meta_q;
    logic [DATA_WIDTH-1:0]  ch_data_q;
    logic                   drained_q;
    logic [31:0]            beat_cnt_q;

    logic                   sel_found_s;
    logic [IDW-1:0]         sel_idx_s;
    logic [IDW-1:0]         cand_s;
    logic                   grant_ok_s;
    logic [IDW-1:0]         acc_idx_s;
    logic [NUM_REQ-1:0]     req_ready_s;
    logic                   accept_s;
    logic                   acc_last_s;
    logic [HDR_WIDTH-1:0]   acc_meta_s;
    logic [DATA_WIDTH-1:0]  acc_data_s;
    logic [IDW-1:0]         rr_ptr_d;
    logic [31:0]            beat_cnt_d;

    // Round-robin search: first valid requester at or above rr_ptr, with wrap.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = {IDW{1'b0}};
        cand_s      = rr_ptr_q;
        // Walk from the farthest candidate down so the nearest one wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s      = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            sel_found_s = sel_found_s | req_valid_i[cand_s];
            sel_idx_s   = req_valid_i[cand_s] ? cand_s : sel_idx_s;
        end
    end

    // Decide which requester may be accepted this cycle and whether it may.
    always_comb begin
        grant_ok_s = 1'b0;
        acc_idx_s  = grant_q;
        case (state_q)
            ST_ARB: begin
                acc_idx_s  = sel_idx_s;
                grant_ok_s = run_q & ~ch_full_i & ~drain_req_i & sel_found_s;
            end
            ST_LOCK: begin
                acc_idx_s  = grant_q;
                grant_ok_s = run_q & ~ch_full_i;
            end
            default: begin
                acc_idx_s  = grant_q;
                grant_ok_s = 1'b0;
            end
        endcase
    end

    assign req_ready_s = grant_ok_s ? (ONE_HOT0 << acc_idx_s) : {NUM_REQ{1'b0}};
    assign accept_s    = grant_ok_s & req_valid_i[acc_idx_s];
    assign acc_last_s  = req_last_i[acc_idx_s];
    assign acc_meta_s  = req_meta_i[int'(acc_idx_s) * HDR_WIDTH +: HDR_WIDTH];
    assign acc_data_s  = req_data_i[int'(acc_idx_s) * DATA_WIDTH +: DATA_WIDTH];
    assign rr_ptr_d    = (acc_idx_s == LAST_ID) ? {IDW{1'b0}} : (acc_idx_s + IDW'(1'b1));
    assign beat_cnt_d  = beat_cnt_q + 32'd1;

    // Arbitration FSM together with the registered channel-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= {IDW{1'b0}};
            grant_q    <= {IDW{1'b0}};
            run_q      <= 1'b0;
            ch_we_q    <= 1'b0;
            ch_meta_q  <= {HDR_WIDTH{1'b0}};
            ch_data_q  <= {DATA_WIDTH{1'b0}};
            drained_q  <= 1'b0;
            beat_cnt_q <= 32'd0;
        end else begin
            run_q     <= 1'b1;
            ch_we_q   <= accept_s;
            drained_q <= (state_q == ST_DRAIN) & drain_req_i;
            if (accept_s) begin
                ch_meta_q  <= acc_meta_s;
                ch_data_q  <= acc_data_s;
                grant_q    <= acc_idx_s;
                beat_cnt_q <= beat_cnt_d;
            end
            // An almost-full channel freezes the state as well as the grants.
            case (state_q)
                ST_ARB: begin
                    if (!ch_full_i && drain_req_i) begin
                        state_q <= ST_DRAIN;
                    end else if (accept_s && acc_last_s) begin
                        rr_ptr_q <= rr_ptr_d;
                    end else if (accept_s) begin
                        state_q <= ST_LOCK;
                    end else begin
                        state_q <= ST_ARB;
                    end
                end
                ST_LOCK: begin
                    if (accept_s && acc_last_s) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= drain_req_i ? ST_DRAIN : ST_ARB;
                    end else begin
                        state_q <= ST_LOCK;
                    end
                end
                ST_DRAIN: begin
                    if (!ch_full_i && !drain_req_i) begin
                        state_q <= ST_ARB;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_ARB;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_s;
    assign ch_write_en_o = ch_we_q;
    assign ch_meta_o     = ch_meta_q;
    assign ch_data_o     = ch_data_q;
    assign drained_o     = drained_q;
    assign grant_id_o    = grant_q;
    assign beat_count_o  = beat_cnt_q;

`ifdef ASE_WRARB_WATCHDOG_EN
    localparam int             WCW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(STARVE_LIMIT);

    logic [WCW-1:0] wait_cnt_q [NUM_REQ];
    logic           starve_hit_s;
    logic           starve_err_q;

    // Any requester whose wait counter has saturated is starving.
    always_comb begin
        starve_hit_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_hit_s = starve_hit_s | (wait_cnt_q[i] == WAIT_MAX);
        end
    end

    // Per-requester saturating wait counters and the sticky starvation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= {WCW{1'b0}};
            end
            starve_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_i[i] && req_ready_s[i]) begin
                    wait_cnt_q[i] <= {WCW{1'b0}};
                end else if (req_valid_i[i] && (wait_cnt_q[i] != WAIT_MAX)) begin
                    wait_cnt_q[i] <= wait_cnt_q[i] + WCW'(1'b1);
                end else begin
                    wait_cnt_q[i] <= wait_cnt_q[i];
                end
            end
            starve_err_q <= starve_err_q | starve_hit_s;
`ifdef ASE_DEBUG
            if (starve_hit_s && !starve_err_q) begin
                $display("wrf_channel_arbiter: requester starvation detected at %0t", $time);
            end
`endif
        end
    end

    assign starve_err_o = starve_err_q;
`else
    assign starve_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wrf_channel_arbiter.sv
// Scoreboard bench for wrf_channel_arbiter: per-requester source queues feed
// the requester ports, each test queues the channel beats it expects in the
// order the round-robin/burst rules dictate, and a monitor pops and compares
// every channel write.
module tb_wrf_channel_arbiter;

    localparam int NR  = 4;
    localparam int HW  = 16;
    localparam int DW  = 32;
    localparam int SL  = 16;
    localparam int IDW = 2;

`ifdef ASE_WRARB_WATCHDOG_EN
    localparam logic EXP_STARVE = 1'b1;
`else
    localparam logic EXP_STARVE = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_last;
    logic [NR*HW-1:0]   req_meta;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic               ch_full;
    logic               ch_write_en;
    logic [HW-1:0]      ch_meta;
    logic [DW-1:0]      ch_data;
    logic               drain_req;
    logic               drained;
    logic [IDW-1:0]     grant_id;
    logic [31:0]        beat_count;
    logic               starve_err;

    int vectors     = 0;
    int miscompares = 0;
    int exp_beats   = 0;

    // source entry: {last, meta, data}; scoreboard entry: {id, meta, data}
    logic [HW+DW:0]       src_q [NR][$];
    logic [IDW+HW+DW-1:0] sb_q [$];
    logic [IDW+HW+DW-1:0] mon_e;
    logic [HW+DW:0]       drv_e;
    logic [NR-1:0]        acc;

    always #5 clk = ~clk;

    wrf_channel_arbiter #(
        .NUM_REQ(NR), .HDR_WIDTH(HW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_last_i(req_last),
        .req_meta_i(req_meta), .req_data_i(req_data),
        .req_ready_o(req_ready), .ch_full_i(ch_full),
        .ch_write_en_o(ch_write_en), .ch_meta_o(ch_meta), .ch_data_o(ch_data),
        .drain_req_i(drain_req), .drained_o(drained),
        .grant_id_o(grant_id), .beat_count_o(beat_count), .starve_err_o(starve_err)
    );

    function automatic logic [HW-1:0] mk_meta(int id, int seq);
        return {4'(id), 12'(seq)};
    endfunction

    function automatic logic [DW-1:0] mk_data(int id, int seq);
        return {8'hC0 | 8'(id), 8'(seq), ~{4'(id), 12'(seq)}};
    endfunction

    task automatic push_src(int id, int seq, logic last);
        src_q[id].push_back({last, mk_meta(id, seq), mk_data(id, seq)});
    endtask

    task automatic expect_beat(int id, int seq);
        sb_q.push_back({IDW'(id), mk_meta(id, seq), mk_data(id, seq)});
        exp_beats++;
    endtask

    task automatic present();
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                drv_e = src_q[i][0];
                req_valid[i]           = 1'b1;
                req_last[i]            = drv_e[HW+DW];
                req_meta[i*HW +: HW]   = drv_e[HW+DW-1:DW];
                req_data[i*DW +: DW]   = drv_e[DW-1:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    function automatic bit all_idle();
        bit idle = (sb_q.size() == 0);
        for (int i = 0; i < NR; i++) idle = idle && (src_q[i].size() == 0);
        return idle;
    endfunction

    // Requester model: a beat is consumed when valid & ready held before the edge.
    always begin
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
        end
        present();
    end

    // Channel monitor: every write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n && ch_write_en) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL chan_extra: got id=%0d meta=%h data=%h, required no beat",
                         grant_id, ch_meta, ch_data);
            end else begin
                mon_e = sb_q.pop_front();
                if ({grant_id, ch_meta, ch_data} !== mon_e) begin
                    miscompares++;
                    $display("FAIL chan_beat: got id=%0d meta=%h data=%h, required id=%0d meta=%h data=%h",
                             grant_id, ch_meta, ch_data, mon_e[IDW+HW+DW-1:HW+DW],
                             mon_e[HW+DW-1:DW], mon_e[DW-1:0]);
                end
            end
        end
    end

    task automatic wait_idle(string name, int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            if (all_idle()) break;
        end
        vectors++;
        if (n == budget) begin
            miscompares++;
            $display("FAIL %s_idle: got %0d beats still expected, required 0", name, sb_q.size());
        end
    endtask

    task automatic check_count(string name);
        vectors++;
        if (beat_count !== 32'(exp_beats)) begin
            miscompares++;
            $display("FAIL %s_count: got %0d, required %0d", name, beat_count, exp_beats);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        sb_q.delete();
        exp_beats = 0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_reset_values(string name);
        vectors++;
        if ({ch_write_en, ch_meta, ch_data, req_ready, grant_id, beat_count, drained, starve_err} !== '0) begin
            miscompares++;
            $display("FAIL %s: got we=%b meta=%h data=%h ready=%b gid=%0d cnt=%0d drained=%b starve=%b, required all zero",
                     name, ch_write_en, ch_meta, ch_data, req_ready, grant_id, beat_count, drained, starve_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset_values");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_round_robin();
        int n;
        @(negedge clk);
        #2;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < NR; i++) begin
                push_src(i, 16 + s, 1'b1);
                expect_beat(i, 16 + s);
            end
        end
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            if (ch_write_en) break;
        end
        vectors++;
        if (n == 10) begin
            miscompares++;
            $display("FAIL rr_first_write: got no write in 10 cycles, required a write");
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (ch_write_en !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_back_to_back: got we=%b at beat %0d, required 1", ch_write_en, c + 1);
            end
        end
        wait_idle("rr", 20);
        check_count("rr");
    endtask

    task automatic test_burst_lock();
        @(negedge clk);
        #2;
        for (int s = 0; s < 4; s++) begin
            push_src(1, 32 + s, s == 3);
            expect_beat(1, 32 + s);
        end
        push_src(2, 40, 1'b1);
        expect_beat(2, 40);
        @(posedge ch_write_en);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (req_ready[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL lock_other_ready: got ready[2]=%b during burst, required 0", req_ready[2]);
            end
        end
        wait_idle("lock", 20);
        check_count("lock");
    endtask

    task automatic test_backpressure();
        int we_seen = 0;
        @(negedge clk);
        #2;
        for (int s = 0; s < 6; s++) begin
            push_src(3, 48 + s, s == 5);
            expect_beat(3, 48 + s);
        end
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        ch_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ch_write_en) we_seen++;
            vectors++;
            if ((req_valid & req_ready) !== 4'b0000) begin
                miscompares++;
                $display("FAIL bp_no_accept: got valid&ready=%b in full cycle %0d, required 0000",
                         req_valid & req_ready, c);
            end
        end
        vectors++;
        if (we_seen > 1) begin
            miscompares++;
            $display("FAIL bp_extra_writes: got %0d writes while full, required at most 1", we_seen);
        end
        @(posedge clk);
        #2;
        ch_full = 1'b0;
        wait_idle("bp", 20);
        check_count("bp");
    endtask

    task automatic test_drain();
        int n;
        @(negedge clk);
        #2;
        for (int s = 0; s < 4; s++) begin
            push_src(0, 64 + s, s == 3);
            expect_beat(0, 64 + s);
        end
        push_src(1, 72, 1'b1);
        expect_beat(1, 72);
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        drain_req = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (drained) break;
        end
        vectors++;
        if (n == 20) begin
            miscompares++;
            $display("FAIL drain_reach: got drained=0 after 20 cycles, required 1");
        end
        vectors++;
        if (sb_q.size() != 1) begin
            miscompares++;
            $display("FAIL drain_burst_done: got %0d beats outstanding, required 1", sb_q.size());
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if ({drained, req_ready, ch_write_en, req_valid[1]} !== {1'b1, 4'b0000, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL drain_hold: got drained=%b ready=%b we=%b valid1=%b, required 1 0000 0 1",
                         drained, req_ready, ch_write_en, req_valid[1]);
            end
        end
        @(posedge clk);
        #2;
        drain_req = 1'b0;
        wait_idle("drain", 20);
        vectors++;
        if (drained !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_release: got drained=%b, required 0", drained);
        end
        check_count("drain");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        for (int s = 0; s < 4; s++) begin
            push_src(2, 80 + s, s == 3);
            expect_beat(2, 80 + s);
        end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset_values");
        for (int i = 0; i < NR; i++) src_q[i].delete();
        sb_q.delete();
        exp_beats = 0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        push_src(3, 90, 1'b1);
        expect_beat(3, 90);
        wait_idle("post_reset", 20);
        check_count("post_reset");
        vectors++;
        if (grant_id !== 2'd3) begin
            miscompares++;
            $display("FAIL post_reset_grant: got %0d, required 3", grant_id);
        end
    endtask

    task automatic test_watchdog();
        @(negedge clk);
        #2;
        for (int s = 0; s < 40; s++) begin
            push_src(0, 100 + s, 1'b0);
            expect_beat(0, 100 + s);
        end
        push_src(3, 200, 1'b1);
        repeat (24) @(negedge clk);
        vectors++;
        if (starve_err !== EXP_STARVE) begin
            miscompares++;
            $display("FAIL wd_set: got starve_err=%b, required %b", starve_err, EXP_STARVE);
        end
        repeat (30) @(negedge clk);
        vectors++;
        if (starve_err !== EXP_STARVE) begin
            miscompares++;
            $display("FAIL wd_sticky: got starve_err=%b, required %b", starve_err, EXP_STARVE);
        end
        apply_reset();
        @(negedge clk);
        vectors++;
        if (starve_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_reset_clear: got starve_err=%b, required 0", starve_err);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ch_full   = 1'b0;
        drain_req = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_meta  = '0;
        req_data  = '0;
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_backpressure();
        test_drain();
        test_async_reset();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no completion by %0t, required completion", $time);
        $fatal(1, "bench time limit exceeded");
    end

endmodule
